// File: rtl/order_defines_pkg.sv
// Shared definitions for the order book heap: command codes, heap ordering
// types, FSM state encoding and the key-extract macro.
`ifndef ORDER_DEFINES_PKG_SV
`define ORDER_DEFINES_PKG_SV

// Extracts the compare key field [msb:lsb] from a heap entry.
`define ORDER_KEY(entry, msb, lsb) entry[msb:lsb]

package order_defines;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'd0,
        CMD_PUSH    = 2'd1,
        CMD_POP     = 2'd2,
        CMD_REPLACE = 2'd3
    } cmd_e;

    // TYPE_BID keeps the highest key at the root, TYPE_ASK the lowest.
    typedef enum logic {
        TYPE_BID = 1'b0,
        TYPE_ASK = 1'b1
    } heap_type_e;

    typedef enum logic [3:0] {
        IDLE,
        PUSH_WR,
        PUSH_RD,
        PUSH_WAIT,
        PUSH_CMP,
        POP_RD,
        POP_WAIT,
        REP_WR,
        SIFT_CHK,
        SIFT_RD_L,
        SIFT_WAIT_L,
        SIFT_RD_R,
        SIFT_WAIT_R,
        SIFT_CMP,
        SIFT_WR,
        FIN
    } heap_state_e;

endpackage

`endif

// File: rtl/heap_ram.sv
// Single-port heap storage with registered read data (1-cycle latency).
// Contents are deliberately not reset; slots above the live count are
// don't-care.
module heap_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write on we; read-before-write registered output every cycle.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/order_heap.sv
// Binary heap of order entries (max-heap for bids, min-heap for asks) kept in
// a single-port RAM, 1-based. PUSH bubbles up, POP/REPLACE sift down, and the
// best entry is mirrored in root_data whenever index 1 is written.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE outside reset, and
// cmd_valid is ignored otherwise (nothing is queued).
module order_heap
    import order_defines::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 10,
    parameter int         KEY_MSB   = 31,
    parameter int         KEY_LSB   = 16,
    parameter heap_type_e HEAP_TYPE = TYPE_BID
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] root_data,
    output logic              root_valid,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              done,
    output logic              err,
    output heap_state_e       dbg_state
);

    // One extra bit so 2i and 2i+1 never wrap at the last level.
    localparam int                IW       = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] CAP      = '1;
    localparam logic [IW-1:0]     ROOT_IDX = IW'(1);

    heap_state_e       state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] left_q;   // parent during PUSH, left child during sift
    logic [DATA_W-1:0] right_q;
    logic              has_right;

    logic [IW-1:0]     cnt_x, left_idx, right_idx, parent_idx, best_idx;
    logic              right_exists;
    logic [DATA_W-1:0] best_data;
    logic              best_is_right;

    logic              ram_we;
    logic [IW-1:0]     ram_idx;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic [KEY_MSB-KEY_LSB:0] k_held, k_left, k_right, k_best;
    logic held_beats_left, right_beats_left, best_beats_held;

    assign cnt_x        = {1'b0, count};
    assign left_idx     = {idx[IW-2:0], 1'b0};
    assign right_idx    = {idx[IW-2:0], 1'b1};
    assign parent_idx   = idx >> 1;
    assign right_exists = (right_idx <= cnt_x);

    assign k_held  = `ORDER_KEY(held, KEY_MSB, KEY_LSB);
    assign k_left  = `ORDER_KEY(left_q, KEY_MSB, KEY_LSB);
    assign k_right = `ORDER_KEY(right_q, KEY_MSB, KEY_LSB);
    assign k_best  = `ORDER_KEY(best_data, KEY_MSB, KEY_LSB);

    // Strict comparisons: equal keys never swap, equal children pick left.
    generate
        if (HEAP_TYPE == TYPE_BID) begin : g_bid
            assign held_beats_left  = (k_held  > k_left);
            assign right_beats_left = (k_right > k_left);
            assign best_beats_held  = (k_best  > k_held);
        end else begin : g_ask
            assign held_beats_left  = (k_held  < k_left);
            assign right_beats_left = (k_right < k_left);
            assign best_beats_held  = (k_best  < k_held);
        end
    endgenerate

    assign best_is_right = has_right && right_beats_left;
    assign best_data     = best_is_right ? right_q : left_q;
    assign best_idx      = best_is_right ? right_idx : left_idx;

    assign cmd_ready  = (state == IDLE) && !rst;
    assign root_valid = !empty;
    assign empty      = (count == '0);
    assign full       = (count == CAP);
    assign dbg_state  = state;

    heap_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_idx[ADDR_W-1:0]),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // RAM port steering: address, write enable and write data per state.
    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = idx;
        ram_wdata = held;
        case (state)
            PUSH_WR:   ram_we = 1'b1;
            PUSH_RD:   ram_idx = parent_idx;
            PUSH_CMP:  if (held_beats_left) begin
                           ram_we    = 1'b1;
                           ram_wdata = left_q;
                       end
            POP_RD:    ram_idx = cnt_x;
            POP_WAIT:  begin
                           ram_idx   = cnt_x;
                           ram_we    = 1'b1;
                           ram_wdata = '0;
                       end
            REP_WR:    ram_we = 1'b1;
            SIFT_RD_L: ram_idx = left_idx;
            SIFT_RD_R: ram_idx = right_idx;
            SIFT_CMP:  if (best_beats_held) begin
                           ram_we    = 1'b1;
                           ram_wdata = best_data;
                       end
            SIFT_WR:   ram_we = 1'b1;
            default:   ;
        endcase
        if (rst) ram_we = 1'b0;
    end

    // Heap control FSM; root_data tracks every write to index 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            root_data <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            held      <= '0;
            left_q    <= '0;
            right_q   <= '0;
            has_right <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (ram_we && ram_idx == ROOT_IDX) root_data <= ram_wdata;
            case (state)
                IDLE: if (cmd_valid) begin
                    case (cmd)
                        CMD_PUSH: if (full) err <= 1'b1;
                                  else begin
                                      count <= count + 1'b1;
                                      idx   <= cnt_x + 1'b1;
                                      held  <= cmd_data;
                                      state <= PUSH_WR;
                                  end
                        CMD_POP:  if (empty) err <= 1'b1;
                                  else state <= POP_RD;
                        CMD_REPLACE: if (empty) err <= 1'b1;
                                  else begin
                                      idx   <= ROOT_IDX;
                                      held  <= cmd_data;
                                      state <= REP_WR;
                                  end
                        default:  ;
                    endcase
                end
                PUSH_WR: if (idx == ROOT_IDX) begin
                             state <= FIN;
                             done  <= 1'b1;
                         end else state <= PUSH_RD;
                PUSH_RD:   state <= PUSH_WAIT;
                PUSH_WAIT: begin
                               left_q <= ram_rdata;
                               state  <= PUSH_CMP;
                           end
                PUSH_CMP:  if (held_beats_left) begin
                               idx   <= parent_idx;
                               state <= PUSH_WR;
                           end else begin
                               state <= FIN;
                               done  <= 1'b1;
                           end
                POP_RD:    state <= POP_WAIT;
                POP_WAIT:  begin
                               held  <= ram_rdata;
                               count <= count - 1'b1;
                               idx   <= ROOT_IDX;
                               if (count == ADDR_W'(1)) begin
                                   state <= FIN;
                                   done  <= 1'b1;
                               end else state <= SIFT_CHK;
                           end
                REP_WR:    state <= SIFT_CHK;
                SIFT_CHK:  state <= (left_idx > cnt_x) ? SIFT_WR : SIFT_RD_L;
                SIFT_RD_L: state <= SIFT_WAIT_L;
                SIFT_WAIT_L: begin
                               left_q    <= ram_rdata;
                               has_right <= right_exists;
                               state     <= right_exists ? SIFT_RD_R : SIFT_CMP;
                           end
                SIFT_RD_R: state <= SIFT_WAIT_R;
                SIFT_WAIT_R: begin
                               right_q <= ram_rdata;
                               state   <= SIFT_CMP;
                           end
                SIFT_CMP:  if (best_beats_held) begin
                               idx   <= best_idx;
                               state <= SIFT_CHK;
                           end else state <= SIFT_WR;
                SIFT_WR:   begin
                               state <= FIN;
                               done  <= 1'b1;
                           end
                FIN:       state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule
